exe_mem_wb_pipe: RTL and testbench
==================================

Name: exe_mem_wb_pipe

Overview:
- Parametrised, multi-stage successor to the single-stage EX/MEM→WB latch.
- Carries ALU result, memory read data, writeback enable, load flag and destination register address through DEPTH stages.
- Adds per-stage valid tracking, stall (hold), flush (bubble insert), a resolved writeback-data output and a two-port forwarding lookup across all stages.
- Sits between the execute/memory stage and the register-file writeback port.

Parameters:
- DATA_W, 10, width of ALU result, RAM read data and forwarded data.
- ADDR_W, 3, width of the register-file address field.
- DEPTH, 1, number of pipeline stages (legal range 1..4).
- ZERO_REG, 1, when 1 register address 0 is never forwarded and never written back.

Ports:
- clk  in  1  pipeline clock; all stage registers capture on the falling edge.
- reset  in  1  asynchronous, active-low; clears every stage immediately.
- stall  in  1  hold all stages.
- flush  in  1  load a bubble into stage 0.
- valid_in  in  1  incoming entry is a real instruction.
- alu_result_in  in  DATA_W  ALU result.
- ram_rdata_in  in  DATA_W  memory read data.
- gp_reg_wb_in  in  1  register-file write enable.
- mem_re_in  in  1  entry is a load.
- gp_rdata2_address_in  in  ADDR_W  destination register address.
- alu_result_out  out  DATA_W  last-stage ALU result.
- ram_rdata_out  out  DATA_W  last-stage RAM data.
- gp_reg_wb_out  out  1  last-stage write enable, qualified (see Behaviour).
- mem_re_out  out  1  last-stage load flag.
- gp_rdata2_address_out  out  ADDR_W  last-stage destination address.
- valid_out  out  1  last stage holds a real instruction.
- wb_data_out  out  DATA_W  ram_rdata_out if mem_re_out else alu_result_out.
- fwd_addr_a, fwd_addr_b  in  ADDR_W  source addresses to look up.
- fwd_hit_a, fwd_hit_b  out  1  a matching in-flight writer exists.
- fwd_data_a, fwd_data_b  out  DATA_W  forwarded value, 0 when there is no hit.

Behaviour:
- Reset (reset=0, asynchronous) clears all stage fields to 0 in every stage. All outputs therefore read 0, including valid_out, gp_reg_wb_out and fwd_hit_*. Asserting reset mid-stall or mid-flush discards all entries.
- Entry qualification: the stored write enable is gp_reg_wb_in & valid_in. When ZERO_REG=1, an address of 0 also forces the stored write enable to 0.
- Normal advance (stall=0, flush=0):
  - stage 0 <= inputs;
  - stage k <= stage k-1.
  - Latency is DEPTH falling edges from input to the *_out ports.
- Stall (stall=1, flush=0): every stage holds, including valid and enable bits.
- Flush (flush=1): stage 0 <= bubble (valid=0, wb=0, mem_re=0, data=0, addr=0), regardless of stall.
  - Stages 1..DEPTH-1 hold if stall=1, otherwise shift.
  - Flush has priority over stall at stage 0 only.
- Bubbles propagate with all-zero fields; gp_reg_wb_out=1 only if valid_out=1.
- wb_data_out is combinational from the last stage.
- Forwarding (combinational, per port X in {a,b}):
  - Stage candidate data is ram_rdata if mem_re else alu_result.
  - A stage matches when valid & wb & (addr == fwd_addr_X).
  - When multiple stages match, the youngest wins (stage 0 has highest priority).
  - With ZERO_REG=1, fwd_addr_X==0 never hits.
  - No match: hit=0, data=0.
- DEPTH=1: single stage, which is the same as the legacy latch plus stall/flush/valid/forwarding.

Decomposition:
- Package exe_mem_wb_pkg:
  - stage entry struct (valid, wb, mem_re, alu_result, ram_rdata, addr), sized by DATA_W/ADDR_W through package constants;
  - BUBBLE constant.
- Sub-module exe_mem_wb_stage: one stage register with async active-low clear, hold enable and bubble-load. The top instantiates DEPTH copies in a generate loop and adds the forwarding priority mux.

Test Plan:
- Reset: drive reset=0 mid-stream with valid entries in flight → all outputs 0 immediately. After release with valid_in=1, alu=10'h155, addr=3, wb=1 and DEPTH=2, the entry appears at the outputs after 2 falling edges with wb_data_out=10'h155.
- Stall: load entries alu=10'h001 then 10'h002, assert stall for 3 edges → outputs frozen at the first entry. Deassert → 10'h002 appears on the next edge, with no duplication or loss.
- Flush with stall: stall=1 and flush=1 for one edge with stage 0 holding addr=5 → stage 0 becomes a bubble. When it reaches the last stage, valid_out=0 and gp_reg_wb_out=0.
- Load select: mem_re_in=1, ram_rdata=10'h2AA, alu=10'h0FF → wb_data_out=10'h2AA and mem_re_out=1.
- Forward priority (DEPTH=3): stage 2 writes r4=10'h011 and stage 0 writes r4=10'h022, with fwd_addr_a=4 → fwd_hit_a=1 and fwd_data_a=10'h022. With fwd_addr_b=6 → fwd_hit_b=0 and fwd_data_b=0.
- Zero register: valid write to addr=0 with fwd_addr_a=0 → fwd_hit_a=0, and gp_reg_wb_out=0 at the output.

Source files
------------

// File: rtl/exe_mem_wb_pkg.sv
// Shared types for the EX/MEM->WB pipeline: the per-stage entry record,
// the bubble constant and small helpers used by the forwarding network.
package exe_mem_wb_pkg;

  localparam int PKG_DATA_W = 10;
  localparam int PKG_ADDR_W = 3;

  typedef struct packed {
    logic                  valid;
    logic                  wb;
    logic                  mem_re;
    logic [PKG_DATA_W-1:0] alu_result;
    logic [PKG_DATA_W-1:0] ram_rdata;
    logic [PKG_ADDR_W-1:0] addr;
  } stage_t;

  localparam stage_t BUBBLE = '{
    valid:      1'b0,
    wb:         1'b0,
    mem_re:     1'b0,
    alu_result: {PKG_DATA_W{1'b0}},
    ram_rdata:  {PKG_DATA_W{1'b0}},
    addr:       {PKG_ADDR_W{1'b0}}
  };

  // Value this entry would write back: loads deliver memory data.
  function automatic logic [PKG_DATA_W-1:0] stage_wb_data(input stage_t s);
    return s.mem_re ? s.ram_rdata : s.alu_result;
  endfunction

  function automatic logic stage_match(input stage_t s, input logic [PKG_ADDR_W-1:0] a);
    return s.valid & s.wb & (s.addr == a);
  endfunction

endpackage

// File: rtl/exe_mem_wb_stage.sv
// One pipeline stage register, captured on the falling clock edge, with
// asynchronous clear, hold and bubble-load controls.
module exe_mem_wb_stage
  import exe_mem_wb_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   hold,
  input  logic   load_bubble,
  input  stage_t d,
  output stage_t q
);

  stage_t q_r;

  // Stage register: bubble-load wins over hold so a flush always lands.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      q_r <= BUBBLE;
    end else if (load_bubble) begin
      q_r <= BUBBLE;
    end else if (!hold) begin
      q_r <= d;
    end else begin
      q_r <= q_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/exe_mem_wb_pipe.sv
// DEPTH-stage EX/MEM->WB pipeline with stall, flush, valid tracking, resolved
// writeback data and a two-port youngest-first forwarding lookup.
module exe_mem_wb_pipe
  import exe_mem_wb_pkg::*;
#(
  parameter int DATA_W   = PKG_DATA_W,
  parameter int ADDR_W   = PKG_ADDR_W,
  parameter int DEPTH    = 1,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [DATA_W-1:0] ram_rdata_in,
  input  logic              gp_reg_wb_in,
  input  logic              mem_re_in,
  input  logic [ADDR_W-1:0] gp_rdata2_address_in,
  output logic [DATA_W-1:0] alu_result_out,
  output logic [DATA_W-1:0] ram_rdata_out,
  output logic              gp_reg_wb_out,
  output logic              mem_re_out,
  output logic [ADDR_W-1:0] gp_rdata2_address_out,
  output logic              valid_out,
  output logic [DATA_W-1:0] wb_data_out,
  input  logic [ADDR_W-1:0] fwd_addr_a,
  input  logic [ADDR_W-1:0] fwd_addr_b,
  output logic              fwd_hit_a,
  output logic              fwd_hit_b,
  output logic [DATA_W-1:0] fwd_data_a,
  output logic [DATA_W-1:0] fwd_data_b
);

  stage_t            in_s;
  stage_t            last_s;
  stage_t            stage_d_s [DEPTH];
  stage_t            stage_q_s [DEPTH];
  logic              zero_addr_s;
  logic              fwd_en_a_s;
  logic              fwd_en_b_s;
  logic              hit_a_s;
  logic              hit_b_s;
  logic [DATA_W-1:0] data_a_s;
  logic [DATA_W-1:0] data_b_s;

  assign zero_addr_s = (ZERO_REG != 0) && (gp_rdata2_address_in == {ADDR_W{1'b0}});
  assign fwd_en_a_s  = !((ZERO_REG != 0) && (fwd_addr_a == {ADDR_W{1'b0}}));
  assign fwd_en_b_s  = !((ZERO_REG != 0) && (fwd_addr_b == {ADDR_W{1'b0}}));

  // Qualify the incoming entry: only valid, non-zero-register writes keep wb.
  always_comb begin
    in_s            = BUBBLE;
    in_s.valid      = valid_in;
    in_s.wb         = gp_reg_wb_in & valid_in & ~zero_addr_s;
    in_s.mem_re     = mem_re_in;
    in_s.alu_result = alu_result_in;
    in_s.ram_rdata  = ram_rdata_in;
    in_s.addr       = gp_rdata2_address_in;
  end

  // Flush only bubbles stage 0; the older stages follow the stall alone.
  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    if (g == 0) begin : g_head
      assign stage_d_s[g] = in_s;
    end else begin : g_tail
      assign stage_d_s[g] = stage_q_s[g-1];
    end

    exe_mem_wb_stage u_stage (
      .clk         (clk),
      .reset       (reset),
      .hold        (stall),
      .load_bubble ((g == 0) ? flush : 1'b0),
      .d           (stage_d_s[g]),
      .q           (stage_q_s[g])
    );
  end

  assign last_s                = stage_q_s[DEPTH-1];
  assign alu_result_out        = last_s.alu_result;
  assign ram_rdata_out         = last_s.ram_rdata;
  assign gp_reg_wb_out         = last_s.wb & last_s.valid;
  assign mem_re_out            = last_s.mem_re;
  assign gp_rdata2_address_out = last_s.addr;
  assign valid_out             = last_s.valid;
  assign wb_data_out           = stage_wb_data(last_s);

  // Forwarding mux: scan oldest to youngest so the youngest match overrides.
  always_comb begin
    hit_a_s  = 1'b0;
    hit_b_s  = 1'b0;
    data_a_s = {DATA_W{1'b0}};
    data_b_s = {DATA_W{1'b0}};
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (fwd_en_a_s && stage_match(stage_q_s[k], fwd_addr_a)) begin
        hit_a_s  = 1'b1;
        data_a_s = stage_wb_data(stage_q_s[k]);
      end else begin
        hit_a_s  = hit_a_s;
        data_a_s = data_a_s;
      end
      if (fwd_en_b_s && stage_match(stage_q_s[k], fwd_addr_b)) begin
        hit_b_s  = 1'b1;
        data_b_s = stage_wb_data(stage_q_s[k]);
      end else begin
        hit_b_s  = hit_b_s;
        data_b_s = data_b_s;
      end
    end
  end

  assign fwd_hit_a  = hit_a_s;
  assign fwd_hit_b  = hit_b_s;
  assign fwd_data_a = data_a_s;
  assign fwd_data_b = data_b_s;

endmodule

// File: tb/tb_exe_mem_wb_pipe.sv
// Bench for exe_mem_wb_pipe: DEPTH=2 and DEPTH=3 instances share one stimulus
// stream and are checked against a behavioural entry-list model every cycle.
module tb_exe_mem_wb_pipe;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       stall = 1'b0;
  logic       flush = 1'b0;
  logic       valid_in = 1'b0;
  logic       wb_in = 1'b0;
  logic       re_in = 1'b0;
  logic [9:0] alu_in = 10'h000;
  logic [9:0] ram_in = 10'h000;
  logic [2:0] addr_in = 3'd0;
  logic [2:0] fa = 3'd0;
  logic [2:0] fb = 3'd0;

  logic [9:0] o2_alu, o2_ram, o2_wbd, o2_fda, o2_fdb;
  logic [9:0] o3_alu, o3_ram, o3_wbd, o3_fda, o3_fdb;
  logic [2:0] o2_addr, o3_addr;
  logic       o2_wb, o2_re, o2_v, o2_ha, o2_hb;
  logic       o3_wb, o3_re, o3_v, o3_ha, o3_hb;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  exe_mem_wb_pipe #(.DATA_W(10), .ADDR_W(3), .DEPTH(2), .ZERO_REG(1)) u_d2 (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .valid_in(valid_in),
    .alu_result_in(alu_in), .ram_rdata_in(ram_in), .gp_reg_wb_in(wb_in),
    .mem_re_in(re_in), .gp_rdata2_address_in(addr_in),
    .alu_result_out(o2_alu), .ram_rdata_out(o2_ram), .gp_reg_wb_out(o2_wb),
    .mem_re_out(o2_re), .gp_rdata2_address_out(o2_addr), .valid_out(o2_v),
    .wb_data_out(o2_wbd), .fwd_addr_a(fa), .fwd_addr_b(fb),
    .fwd_hit_a(o2_ha), .fwd_hit_b(o2_hb), .fwd_data_a(o2_fda), .fwd_data_b(o2_fdb)
  );

  exe_mem_wb_pipe #(.DATA_W(10), .ADDR_W(3), .DEPTH(3), .ZERO_REG(1)) u_d3 (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .valid_in(valid_in),
    .alu_result_in(alu_in), .ram_rdata_in(ram_in), .gp_reg_wb_in(wb_in),
    .mem_re_in(re_in), .gp_rdata2_address_in(addr_in),
    .alu_result_out(o3_alu), .ram_rdata_out(o3_ram), .gp_reg_wb_out(o3_wb),
    .mem_re_out(o3_re), .gp_rdata2_address_out(o3_addr), .valid_out(o3_v),
    .wb_data_out(o3_wbd), .fwd_addr_a(fa), .fwd_addr_b(fb),
    .fwd_hit_a(o3_ha), .fwd_hit_b(o3_hb), .fwd_data_a(o3_fda), .fwd_data_b(o3_fdb)
  );

  // Model: list of in-flight instructions, youngest at index 0. The DEPTH=2
  // pipe sees entries 0..1, the DEPTH=3 pipe entries 0..2 of the same list.
  typedef struct packed {
    bit       v;
    bit       wb;
    bit       re;
    bit [9:0] alu;
    bit [9:0] ram;
    bit [2:0] a;
  } ent_t;

  ent_t m [3];

  function automatic ent_t incoming();
    ent_t e;
    e     = '0;
    e.v   = valid_in;
    e.wb  = valid_in && wb_in && (addr_in != 3'd0);
    e.re  = re_in;
    e.alu = alu_in;
    e.ram = ram_in;
    e.a   = addr_in;
    return e;
  endfunction

  function automatic bit [9:0] wbval(input ent_t e);
    return e.re ? e.ram : e.alu;
  endfunction

  // {hit, data} of the youngest in-flight writer of register x.
  function automatic bit [10:0] fwd_exp(input int depth, input bit [2:0] x);
    if (x == 3'd0) return 11'd0;
    for (int k = 0; k < depth; k++)
      if (m[k].v && m[k].wb && m[k].a == x) return {1'b1, wbval(m[k])};
    return 11'd0;
  endfunction

  always @(negedge clk or negedge reset) begin
    if (!reset) begin
      m[0] <= '0; m[1] <= '0; m[2] <= '0;
    end else if (!stall) begin
      m[2] <= m[1];
      m[1] <= m[0];
      m[0] <= flush ? ent_t'('0) : incoming();
    end else if (flush) begin
      m[0] <= '0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Every rising edge, mid-way between captures, both pipes against the model.
  always @(posedge clk) begin
    bit [10:0] e2a, e2b, e3a, e3b;
    e2a = fwd_exp(2, fa); e2b = fwd_exp(2, fb);
    e3a = fwd_exp(3, fa); e3b = fwd_exp(3, fb);
    chk("d2.valid_out", o2_v, m[1].v);
    chk("d2.wb_out",    o2_wb, m[1].v & m[1].wb);
    chk("d2.mem_re",    o2_re, m[1].re);
    chk("d2.alu",       o2_alu, m[1].alu);
    chk("d2.ram",       o2_ram, m[1].ram);
    chk("d2.addr",      o2_addr, m[1].a);
    chk("d2.wb_data",   o2_wbd, wbval(m[1]));
    chk("d2.fwd_a",     {o2_ha, o2_fda}, e2a);
    chk("d2.fwd_b",     {o2_hb, o2_fdb}, e2b);
    chk("d3.valid_out", o3_v, m[2].v);
    chk("d3.wb_out",    o3_wb, m[2].v & m[2].wb);
    chk("d3.mem_re",    o3_re, m[2].re);
    chk("d3.alu",       o3_alu, m[2].alu);
    chk("d3.ram",       o3_ram, m[2].ram);
    chk("d3.addr",      o3_addr, m[2].a);
    chk("d3.wb_data",   o3_wbd, wbval(m[2]));
    chk("d3.fwd_a",     {o3_ha, o3_fda}, e3a);
    chk("d3.fwd_b",     {o3_hb, o3_fdb}, e3b);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set_in(input bit v, input bit w, input bit r,
                        input bit [9:0] alu, input bit [9:0] ram, input bit [2:0] a);
    valid_in = v; wb_in = w; re_in = r; alu_in = alu; ram_in = ram; addr_in = a;
  endtask

  typedef struct packed {
    bit       st;
    bit       fl;
    bit       v;
    bit       w;
    bit       r;
    bit [9:0] alu;
    bit [9:0] ram;
    bit [2:0] a;
  } vec_t;

  vec_t vecs [12];

  initial begin
    vecs[0]  = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 10'h101, 10'h000, 3'd1};
    vecs[1]  = {1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 10'h102, 10'h2F0, 3'd2};
    vecs[2]  = {1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 10'h103, 10'h000, 3'd3};
    vecs[3]  = {1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 10'h104, 10'h000, 3'd1};
    vecs[4]  = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'h105, 10'h000, 3'd2};
    vecs[5]  = {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'h106, 10'h000, 3'd1};
    vecs[6]  = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 10'h107, 10'h000, 3'd1};
    vecs[7]  = {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 10'h108, 10'h000, 3'd2};
    vecs[8]  = {1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 10'h109, 10'h1A5, 3'd2};
    vecs[9]  = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 10'h10A, 10'h000, 3'd0};
    vecs[10] = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'h10B, 10'h000, 3'd7};
    vecs[11] = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 10'h10C, 10'h000, 3'd2};

    // Reset held from time zero: everything reads 0.
    tick(); tick();
    chk("rst.d2_valid", o2_v, 1'b0);
    chk("rst.d3_wb_out", o3_wb, 1'b0);
    chk("rst.d3_wb_data", o3_wbd, 10'h000);
    reset = 1'b1;

    // One instruction r3 <- 155 reaches the DEPTH=2 outputs after two edges.
    set_in(1, 1, 0, 10'h155, 10'h000, 3'd3); tick();
    set_in(0, 0, 0, 10'h000, 10'h000, 3'd0); tick();
    chk("lat.d2_valid", o2_v, 1'b1);
    chk("lat.d2_wb_data", o2_wbd, 10'h155);
    chk("lat.d2_wb_out", o2_wb, 1'b1);
    chk("lat.d2_addr", o2_addr, 3'd3);
    chk("lat.d3_valid", o3_v, 1'b0);
    fa = 3'd3; #1;
    chk("lat.d3_fwd_a", {o3_ha, o3_fda}, {1'b1, 10'h155});

    // Asynchronous reset with valid entries in flight.
    set_in(1, 1, 0, 10'h0AA, 10'h000, 3'd2); tick();
    chk("lat.d3_wb_data", o3_wbd, 10'h155);
    fa = 3'd2; #1;
    chk("pre_rst.d2_fwd_a", o2_ha, 1'b1);
    reset = 1'b0; #1;
    chk("rst_mid.d3_valid", o3_v, 1'b0);
    chk("rst_mid.d3_wb_data", o3_wbd, 10'h000);
    chk("rst_mid.d2_fwd_a", {o2_ha, o2_fda}, 11'd0);
    reset = 1'b1;
    fa = 3'd0;

    // Stall freezes the pipe; release resumes with no duplicate or loss.
    set_in(1, 1, 0, 10'h001, 10'h000, 3'd1); tick();
    set_in(1, 1, 0, 10'h002, 10'h000, 3'd2); tick();
    stall = 1'b1;
    set_in(1, 1, 0, 10'h003, 10'h000, 3'd3);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall.d2_alu", o2_alu, 10'h001);
    end
    stall = 1'b0;
    set_in(0, 0, 0, 10'h000, 10'h000, 3'd0); tick();
    chk("unstall.d2_alu", o2_alu, 10'h002);
    tick();
    chk("unstall.d2_valid", o2_v, 1'b0);
    chk("unstall.d3_alu", o3_alu, 10'h002);

    // Flush during stall: stage 0 becomes a bubble, stage 1 stays put.
    set_in(1, 1, 0, 10'h004, 10'h000, 3'd4); tick();
    set_in(1, 1, 0, 10'h005, 10'h000, 3'd5); tick();
    stall = 1'b1; flush = 1'b1; tick();
    stall = 1'b0; flush = 1'b0;
    set_in(0, 0, 0, 10'h000, 10'h000, 3'd0);
    fa = 3'd5; #1;
    chk("flush.d2_alu_held", o2_alu, 10'h004);
    chk("flush.d3_fwd_a", o3_ha, 1'b0);
    tick();
    chk("flush.d2_valid", o2_v, 1'b0);
    chk("flush.d2_wb_out", o2_wb, 1'b0);
    chk("flush.d3_alu", o3_alu, 10'h004);

    // Load selects memory data for writeback and forwarding.
    set_in(1, 1, 1, 10'h0FF, 10'h2AA, 3'd6); fa = 3'd6; tick();
    chk("load.d3_fwd_a", {o3_ha, o3_fda}, {1'b1, 10'h2AA});
    set_in(0, 0, 0, 10'h000, 10'h000, 3'd0); tick();
    chk("load.d2_wb_data", o2_wbd, 10'h2AA);
    chk("load.d2_mem_re", o2_re, 1'b1);
    chk("load.d2_alu", o2_alu, 10'h0FF);

    // Youngest writer wins; unmatched port returns zero.
    set_in(1, 1, 0, 10'h011, 10'h000, 3'd4); tick();
    set_in(1, 1, 0, 10'h033, 10'h000, 3'd7); tick();
    set_in(1, 1, 0, 10'h022, 10'h000, 3'd4); tick();
    set_in(0, 0, 0, 10'h000, 10'h000, 3'd0);
    fa = 3'd4; fb = 3'd6; #1;
    chk("prio.d3_fwd_a", {o3_ha, o3_fda}, {1'b1, 10'h022});
    chk("prio.d3_fwd_b", {o3_hb, o3_fdb}, 11'd0);
    chk("prio.d3_out_alu", o3_alu, 10'h011);
    fb = 3'd7; #1;
    chk("prio.d3_fwd_b7", {o3_hb, o3_fdb}, {1'b1, 10'h033});

    // Register zero is never forwarded nor written back.
    set_in(1, 1, 0, 10'h3FF, 10'h000, 3'd0); fa = 3'd0; tick();
    chk("zero.d3_fwd_a", o3_ha, 1'b0);
    set_in(0, 0, 0, 10'h000, 10'h000, 3'd0); tick(); tick();
    chk("zero.d3_valid", o3_v, 1'b1);
    chk("zero.d3_wb_out", o3_wb, 1'b0);
    chk("zero.d3_alu", o3_alu, 10'h3FF);

    // Mixed stall/flush/load table, checked by the per-cycle model compare.
    fa = 3'd2; fb = 3'd1;
    for (int i = 0; i < 12; i++) begin
      stall = vecs[i].st; flush = vecs[i].fl;
      set_in(vecs[i].v, vecs[i].w, vecs[i].r, vecs[i].alu, vecs[i].ram, vecs[i].a);
      tick();
    end
    stall = 1'b0; flush = 1'b0;
    set_in(0, 0, 0, 10'h000, 10'h000, 3'd0);
    repeat (4) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
